// File: rtl/pc_pkg.sv
// Shared types and constants for the speculative program counter.
package pc_pkg;

  // Reference width of the canonical checkpoint layout.
  localparam int unsigned PC_W = 16;

  // Register-branch offsets come from MinorOpcode scaled by 2**3.
  localparam int unsigned BRANCH_OFFSET_SHIFT = 3;

  // One outstanding speculation: the prediction, where we went, and where to
  // come back to if the prediction turns out wrong.
  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] dest;
    logic [PC_W-1:0] rollback;
  } spec_checkpoint_t;

endpackage

// File: rtl/speculation_checkpoint_fifo.sv
// Circular buffer of speculation checkpoints. Push and pop may occur in the
// same cycle, including when full. Flush empties the buffer and realigns both
// pointers to zero. The head entry is read combinationally.
module speculation_checkpoint_fifo
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;

  // Next pointer/count: flush dominates, otherwise independent push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/speculative_program_counter.sv
// Fetch program counter with a queue of in-order-resolved branch speculations.
// Pulse semantics: ResolvePulse/MispredictPulse are single-cycle combinational
// strobes valid in the cycle ResolveEnable is sampled with a live head entry
// and clk_en high; there is no back-pressure, a resolve is accepted or ignored
// in that same cycle. BeginSpeculation is likewise accepted or dropped in the
// cycle it is presented.
module speculative_program_counter
  import pc_pkg::*;
#(
  parameter int unsigned              DATABITWIDTH = 16,
  parameter int unsigned              SPECDEPTH    = 4,
  parameter logic [DATABITWIDTH-1:0]  RESETVECTOR  = '0
) (
  input  logic                         clk,
  input  logic                         clk_en,
  input  logic                         sync_rst,
  input  logic                         ProgramCounterEnable,
  input  logic                         StallEnable,
  input  logic                         BeginSpeculation,
  input  logic                         PredictingTrue,
  input  logic                         RelativeSpeculation,
  input  logic [DATABITWIDTH-1:0]      SpeculativeDestination,
  input  logic                         ResolveEnable,
  input  logic                         RelativeBranchEnable,
  input  logic [DATABITWIDTH-1:0]      OperandAData,
  input  logic [DATABITWIDTH-1:0]      ImmediateData,
  input  logic [3:0]                   MinorOpcode,
  output logic [DATABITWIDTH-1:0]      ProgramCounterValue,
  output logic [DATABITWIDTH-1:0]      ActualDestination,
  output logic [DATABITWIDTH-1:0]      JumpAndLinkDataOut,
  output logic                         MispredictPulse,
  output logic                         ResolvePulse,
  output logic [$clog2(SPECDEPTH):0]   SpeculationDepth,
  output logic                         SpeculationFull,
  output logic                         ProtocolError
);

  // Same field order as spec_checkpoint_t, sized to this instance's width.
  typedef struct packed {
    logic                    taken;
    logic [DATABITWIDTH-1:0] dest;
    logic [DATABITWIDTH-1:0] rollback;
  } ckpt_t;

  localparam int unsigned CKW = $bits(ckpt_t);

  logic [DATABITWIDTH-1:0] pc_q, pc_d;
  logic                    err_q, err_d;
  ckpt_t                   push_ckpt, head_ckpt;
  logic [CKW-1:0]          head_bits;
  logic                    fifo_full, fifo_empty;
  logic                    resolve_valid, actual_taken, mispredict, pop;
  logic                    begin_req, begin_acc, overflow, empty_resolve;
  logic [DATABITWIDTH-1:0] true_dest, redirect_pc;

  // Checkpoint captured on a begin: rollback is the fall-through address.
  always_comb begin
    push_ckpt.taken    = PredictingTrue;
    push_ckpt.dest     = RelativeSpeculation ? (pc_q + SpeculativeDestination)
                                             : SpeculativeDestination;
    push_ckpt.rollback = pc_q + 1'b1;
  end

  assign head_ckpt = ckpt_t'(head_bits);

  // Resolve compare against the head checkpoint and begin acceptance.
  always_comb begin
    resolve_valid = clk_en && !sync_rst && ResolveEnable && !fifo_empty;
    empty_resolve = clk_en && !sync_rst && ResolveEnable && fifo_empty;
    actual_taken  = (OperandAData == '0);
    true_dest     = RelativeBranchEnable
                  ? (head_ckpt.rollback + ImmediateData)
                  : (OperandAData + (DATABITWIDTH'(MinorOpcode) << BRANCH_OFFSET_SHIFT));
    mispredict    = resolve_valid &&
                    ((head_ckpt.taken != actual_taken) ||
                     (actual_taken && (head_ckpt.dest != true_dest)));
    pop           = resolve_valid && !mispredict;
    redirect_pc   = actual_taken ? true_dest : head_ckpt.rollback;
    begin_req     = clk_en && !sync_rst && !StallEnable && BeginSpeculation;
    begin_acc     = begin_req && (!fifo_full || pop) && !mispredict;
    // A begin that loses to a mispredict is wrong-path, not an overflow.
    overflow      = begin_req && fifo_full && !resolve_valid;
  end

  // Next-PC priority mux.
  always_comb begin
    pc_d = pc_q;
    if (sync_rst)                          pc_d = RESETVECTOR;
    else if (mispredict)                   pc_d = redirect_pc;
    else if (begin_acc && PredictingTrue)  pc_d = push_ckpt.dest;
    else if (clk_en && !StallEnable && ProgramCounterEnable)
                                           pc_d = pc_q + 1'b1;
    err_d = sync_rst ? 1'b0 : (err_q || overflow || empty_resolve);
  end

  // PC and sticky protocol-error registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pc_q  <= RESETVECTOR;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  speculation_checkpoint_fifo #(
    .WIDTH (CKW),
    .DEPTH (SPECDEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (sync_rst),
    .push_i  (begin_acc),
    .pop_i   (pop),
    .flush_i (mispredict),
    .data_i  (push_ckpt),
    .head_o  (head_bits),
    .count_o (SpeculationDepth),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ProgramCounterValue = pc_q;
  assign ActualDestination   = pc_d;
  assign JumpAndLinkDataOut  = head_ckpt.rollback;
  assign MispredictPulse     = mispredict;
  assign ResolvePulse        = resolve_valid;
  assign SpeculationFull     = fifo_full;
  assign ProtocolError       = err_q;

endmodule

// File: tb/tb_speculative_program_counter.sv
// Bench for speculative_program_counter: directed scenarios plus random
// traffic, checked against a queue-based reference model.
module tb_speculative_program_counter;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RV   = 16'h0100;

  logic clk = 1'b0;
  logic clk_en, sync_rst, pce, stall, beg, ptrue, rel, res, rbe;
  logic [W-1:0] sdest, opa, imm;
  logic [3:0]   mop;
  logic [W-1:0] pc_o, adest_o, jal_o;
  logic         mis_o, resp_o, full_o, err_o;
  logic [2:0]   depth_o;

  speculative_program_counter #(
    .DATABITWIDTH (W),
    .SPECDEPTH    (DEPTH),
    .RESETVECTOR  (RV)
  ) dut (
    .clk                    (clk),
    .clk_en                 (clk_en),
    .sync_rst               (sync_rst),
    .ProgramCounterEnable   (pce),
    .StallEnable            (stall),
    .BeginSpeculation       (beg),
    .PredictingTrue         (ptrue),
    .RelativeSpeculation    (rel),
    .SpeculativeDestination (sdest),
    .ResolveEnable          (res),
    .RelativeBranchEnable   (rbe),
    .OperandAData           (opa),
    .ImmediateData          (imm),
    .MinorOpcode            (mop),
    .ProgramCounterValue    (pc_o),
    .ActualDestination      (adest_o),
    .JumpAndLinkDataOut     (jal_o),
    .MispredictPulse        (mis_o),
    .ResolvePulse           (resp_o),
    .SpeculationDepth       (depth_o),
    .SpeculationFull        (full_o),
    .ProtocolError          (err_o)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    bit taken;
    logic [W-1:0] dest;
    logic [W-1:0] rollback;
  } ck_t;

  typedef struct {
    bit rst, en, pce, stall, beg, ptrue, rel, res, rbe;
    logic [W-1:0] sdest, a, imm;
    logic [3:0] mop;
  } stim_t;

  // Reference model state.
  ck_t          spec_q[$];
  logic [W-1:0] m_pc;
  bit           m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.en = 1; s.pce = 0; s.stall = 0; s.beg = 0; s.ptrue = 0;
    s.rel = 0; s.res = 0; s.rbe = 0; s.sdest = '0; s.a = '0; s.imm = '0; s.mop = '0;
    return s;
  endfunction

  function automatic stim_t begin_s(input bit t, input bit r, input logic [W-1:0] d, input bit p);
    stim_t s = idle();
    s.beg = 1; s.ptrue = t; s.rel = r; s.sdest = d; s.pce = p;
    return s;
  endfunction

  function automatic stim_t resolve_s(input logic [W-1:0] a, input bit rb,
                                      input logic [W-1:0] i, input logic [3:0] m);
    stim_t s = idle();
    s.res = 1; s.a = a; s.rbe = rb; s.imm = i; s.mop = m;
    return s;
  endfunction

  // Driver + model step: drive one cycle, check DUT against the model, then
  // advance the model across the coming clock edge.
  task automatic run_cycle(input stim_t s);
    bit res_ok, mis, act_t, breq, bacc, ovf, eres;
    logic [W-1:0] tdest, npc, ck_dest;
    ck_t h;
    @(posedge clk); #1;
    sync_rst = s.rst; clk_en = s.en; pce = s.pce; stall = s.stall; beg = s.beg;
    ptrue = s.ptrue; rel = s.rel; sdest = s.sdest; res = s.res; rbe = s.rbe;
    opa = s.a; imm = s.imm; mop = s.mop;

    res_ok = s.en && !s.rst && s.res && (spec_q.size() > 0);
    eres   = s.en && !s.rst && s.res && (spec_q.size() == 0);
    act_t  = (s.a == 0);
    mis    = 0;
    tdest  = '0;
    if (res_ok) begin
      h = spec_q[0];
      tdest = s.rbe ? W'(h.rollback + s.imm) : W'(s.a + W'(s.mop) * 8);
      mis = (h.taken != act_t) || (act_t && (h.dest != tdest));
    end
    breq = s.en && !s.rst && !s.stall && s.beg;
    bacc = breq && !mis && ((spec_q.size() < DEPTH) || res_ok);
    ovf  = breq && (spec_q.size() == DEPTH) && !res_ok;
    ck_dest = s.rel ? W'(m_pc + s.sdest) : s.sdest;

    if (s.rst)                      npc = RV;
    else if (mis)                   npc = act_t ? tdest : h.rollback;
    else if (bacc && s.ptrue)       npc = ck_dest;
    else if (s.en && !s.stall && s.pce) npc = W'(m_pc + 1);
    else                            npc = m_pc;

    #3;
    check("pc", pc_o, m_pc);
    check("depth", depth_o, spec_q.size());
    check("full", full_o, spec_q.size() == DEPTH);
    check("err", err_o, m_err);
    if (spec_q.size() > 0) check("jal", jal_o, spec_q[0].rollback);
    check("resolve_pulse", resp_o, res_ok);
    check("mispredict_pulse", mis_o, mis);
    check("next_pc", adest_o, npc);

    if (s.rst) begin
      spec_q.delete();
      m_err = 0;
    end else begin
      if (mis) spec_q.delete();
      else if (res_ok) void'(spec_q.pop_front());
      if (bacc) spec_q.push_back('{s.ptrue, ck_dest, W'(m_pc + 1)});
      m_err = m_err || ovf || eres;
    end
    m_pc = npc;
  endtask

  task automatic do_reset();
    stim_t s = idle();
    s.rst = 1;
    run_cycle(s);
  endtask

  initial begin
    stim_t s;
    // Bring the DUT out of its unknown power-up state before model checks.
    sync_rst = 1; clk_en = 1; pce = 0; stall = 0; beg = 0; ptrue = 0; rel = 0;
    sdest = '0; res = 0; rbe = 0; opa = '0; imm = '0; mop = '0;
    repeat (2) @(posedge clk);
    m_pc = RV; m_err = 0; spec_q.delete();

    // Reset and plain increment.
    do_reset();
    check("rst_pc", pc_o, 16'h0100);
    check("rst_depth", depth_o, 0);
    check("rst_pulses", {mis_o, resp_o}, 0);
    s = idle(); s.pce = 1;
    repeat (3) run_cycle(s);
    run_cycle(idle());
    check("pc_0103", pc_o, 16'h0103);

    // Reach 0x0010 through a correctly predicted register branch.
    run_cycle(begin_s(1, 0, 16'h0010, 0));
    run_cycle(resolve_s(16'h0000, 0, 16'h0000, 4'd2));

    // Correct taken branch to 0x0040.
    run_cycle(begin_s(1, 0, 16'h0040, 0));
    run_cycle(resolve_s(16'h0000, 0, 16'h0000, 4'd8));
    check("taken_pc", pc_o, 16'h0040);
    check("taken_jal", jal_o, 16'h0011);
    check("taken_nomis", mis_o, 0);
    run_cycle(idle());
    check("taken_depth", depth_o, 0);

    // Reach 0x0020, then a wrongly predicted not-taken branch.
    run_cycle(begin_s(1, 0, 16'h0020, 0));
    run_cycle(resolve_s(16'h0000, 0, 16'h0000, 4'd4));
    run_cycle(begin_s(0, 0, 16'h0000, 1));
    run_cycle(resolve_s(16'h0000, 1, 16'h0010, 4'd0));
    check("nt_mis", mis_o, 1);
    check("nt_dest", adest_o, 16'h0031);
    run_cycle(idle());
    check("nt_pc", pc_o, 16'h0031);

    // Nested: fill, overflow, mispredict on head flushes everything.
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(begin_s(1, 0, W'(16'h0200 + i), 0));
    run_cycle(begin_s(1, 0, 16'h0300, 0));
    check("nest_full", full_o, 1);
    run_cycle(resolve_s(16'h0001, 0, 16'h0000, 4'd0));
    check("nest_err", err_o, 1);
    check("nest_rollback", adest_o, 16'h0101);
    run_cycle(idle());
    check("nest_depth", depth_o, 0);

    // Simultaneous events on a full queue.
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(begin_s(0, 0, 16'h0000, 1));
    s = resolve_s(16'h0005, 0, 16'h0000, 4'd0);
    s.beg = 1; s.ptrue = 0; s.pce = 1;
    run_cycle(s);
    s = resolve_s(16'h0000, 1, 16'h0010, 4'd0);
    s.beg = 1; s.ptrue = 1; s.sdest = 16'h0777;
    run_cycle(s);
    check("sim_full_depth", depth_o, 4);
    check("sim_full_err", err_o, 0);
    check("sim_mis_dest", adest_o, 16'h0112);
    run_cycle(idle());
    check("sim_mis_depth", depth_o, 0);

    // Stall: redirect still happens, otherwise PC holds.
    run_cycle(begin_s(0, 0, 16'h0000, 1));
    s = resolve_s(16'h0000, 1, 16'h0005, 4'd0);
    s.stall = 1;
    run_cycle(s);
    check("stall_redirect", adest_o, 16'h0118);
    s = idle(); s.stall = 1; s.pce = 1;
    run_cycle(s);
    check("stall_hold", pc_o, 16'h0118);

    // Random traffic; roughly half the resolves are steered to be correct.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      s.rst   = ($urandom_range(63) == 0);
      s.en    = ($urandom_range(9) != 0);
      s.pce   = 1'($urandom_range(1));
      s.stall = ($urandom_range(4) == 0);
      s.beg   = ($urandom_range(2) == 0);
      s.ptrue = 1'($urandom_range(1));
      s.rel   = 1'($urandom_range(1));
      s.sdest = W'($urandom);
      s.res   = ($urandom_range(2) == 0);
      s.rbe   = 1'($urandom_range(1));
      s.a     = ($urandom_range(1) == 0) ? '0 : W'($urandom);
      s.imm   = W'($urandom);
      s.mop   = 4'($urandom_range(15));
      if (spec_q.size() > 0 && $urandom_range(1) == 1) begin
        if (spec_q[0].taken) begin
          s.a = '0; s.rbe = 1;
          s.imm = W'(spec_q[0].dest - spec_q[0].rollback);
        end else begin
          s.a = W'($urandom_range(65535, 1));
        end
      end
      run_cycle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
